// File: rtl/tick_sched.sv
// Multi-channel trig-edge divider with a round-robin valid/ready event port.
// Optional debug edge counter is built when TICK_SCHED_DBG_EN is defined.
module tick_sched #(
  parameter int CH          = 4,
  parameter int CNT_W       = 16,
  parameter int PERIOD_INIT = 1,
  parameter int DBG_CNT     = 1024,
  localparam int CH_W       = $clog2(CH),
  localparam int DBG_W      = $clog2(DBG_CNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [CH-1:0]    cfg_en,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  output logic             ev_valid,
  output logic [CH_W-1:0]  ev_ch,
  input  logic             ev_ready,
  output logic [CH-1:0]    miss,
  output logic [DBG_W-1:0] dbg_cnt
);

  logic             last;
  logic             trig_edge;
  logic [CNT_W-1:0] period   [CH];
  logic [CNT_W-1:0] cnt      [CH];
  logic [CNT_W-1:0] last_cnt [CH];
  logic [CH_W-1:0]  cand     [CH];
  logic [CH-1:0]    pending;
  logic [CH-1:0]    fire;
  logic [CH-1:0]    we_hit;
  logic [CH-1:0]    sel_mask;
  logic [CH_W-1:0]  rr;
  logic [CH_W-1:0]  sel_idx;
  logic             sel_any;
  logic             load;

  assign trig_edge = trig ^ last;
  assign load      = !ev_valid || ev_ready;

  // A period of 0 counts as 1, so the terminal count is 0 in both cases.
  always_comb begin
    we_hit = '0;
    if (cfg_we) we_hit[cfg_ch] = 1'b1;
    for (int c = 0; c < CH; c++) begin
      last_cnt[c] = (period[c] == '0) ? '0 : period[c] - CNT_W'(1);
      fire[c]     = trig_edge && cfg_en[c] && !we_hit[c] && (cnt[c] == last_cnt[c]);
    end
  end

  // Scan from farthest to nearest after rr so the nearest pending bit wins.
  always_comb begin
    sel_any  = 1'b0;
    sel_idx  = rr;
    sel_mask = '0;
    for (int i = 0; i < CH; i++) begin
      cand[i] = CH_W'((int'(rr) + i + 1) % CH);
    end
    for (int i = CH - 1; i >= 0; i--) begin
      if (pending[cand[i]]) begin
        sel_any = 1'b1;
        sel_idx = cand[i];
      end
    end
    if (load && sel_any) sel_mask[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= 1'b0;
      pending <= '0;
      miss    <= '0;
      for (int c = 0; c < CH; c++) begin
        cnt[c]    <= '0;
        period[c] <= CNT_W'(PERIOD_INIT);
      end
    end else begin
      last <= trig;
      for (int c = 0; c < CH; c++) begin
        if (we_hit[c]) period[c] <= cfg_period;
        if (!cfg_en[c] || we_hit[c]) begin
          cnt[c]     <= '0;
          pending[c] <= 1'b0;
        end else begin
          if (trig_edge) cnt[c] <= fire[c] ? '0 : cnt[c] + CNT_W'(1);
          pending[c] <= (pending[c] && !sel_mask[c]) || fire[c];
        end
      end
      miss <= pending & fire & ~sel_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_ch    <= '0;
      rr       <= CH_W'(CH - 1);
    end else if (load) begin
      if (sel_any) begin
        ev_valid <= 1'b1;
        ev_ch    <= sel_idx;
        rr       <= sel_idx;
      end else begin
        ev_valid <= 1'b0;
      end
    end
  end

`ifdef TICK_SCHED_DBG_EN
  (* PAP_MARK_DEBUG = "1" *) logic [DBG_W-1:0] dbg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_q <= '0;
    end else if (trig_edge) begin
      dbg_q <= (dbg_q == DBG_W'(DBG_CNT - 1)) ? '0 : dbg_q + DBG_W'(1);
    end
  end

  assign dbg_cnt = dbg_q;
`else
  assign dbg_cnt = '0;
`endif

endmodule
